pwm_sequencer: RTL and testbench
================================

Name: pwm_sequencer

Overview:
- Multi-channel PWM controller that owns one shared period counter and sequences it for NCH channels.
- Configuration writes go to shadow registers through a valid/ready port. Shadow values become active only at a period boundary, so no PWM cycle is ever torn.
- Sits between the host/config logic and the PWM output pins; replaces free-running per-channel counters.

Parameters:
- WIDTH, 4, bit width of the period counter, period and duty values.
- NCH, 4, number of PWM channels.
- PW, 8, bit width of the prescaler.
- AW, 3, config address width; must satisfy 2^AW >= NCH+2.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  run request: level high = run, low = stop at the end of the current period.
- CFG_VALID  in  1  config write request.
- CFG_READY  out  1  config write accepted when VALID&&READY.
- CFG_ADDR  in  AW  0..NCH-1 = duty of channel n; NCH = period; NCH+1 = prescale.
- CFG_DATA  in  max(WIDTH,PW)  write data; LSBs used per target width.
- CFG_ERR  out  1  one-cycle pulse on an accepted write to an address >= NCH+2.
- PWM_OUT  out  NCH  registered PWM outputs.
- PERIOD_TICK  out  1  one-cycle pulse when the counter wraps.
- BUSY  out  1  high in RUN and DRAIN.

Behaviour:
- Reset (RST low, async):
  - state=IDLE; cnt=0; prescaler=0.
  - All shadow and active duty = 0.
  - Shadow and active period = 2^WIDTH-1; shadow and active prescale = 0.
  - PWM_OUT=0, PERIOD_TICK=0, CFG_ERR=0, BUSY=0, CFG_READY=1.
- Tick generation: prescaler counts 0..PRESC_active. tick=1 in the cycle the prescaler equals PRESC_active, and the prescaler wraps to 0 in that same cycle. PRESC=0 gives a tick every cycle.
- States:
  - IDLE: cnt and prescaler held at 0; PWM_OUT=0. If EN=1, copy all shadow regs to active and go to RUN.
  - RUN: on tick, cnt increments. If cnt==PERIOD_active at a tick, then:
    - cnt wraps to 0 and PERIOD_TICK pulses in the next cycle;
    - all shadow regs are copied to active;
    - if EN=0, go to DRAIN, else stay in RUN.
  - DRAIN: exactly one cycle. PWM_OUT forced to 0, then go to IDLE. EN=0 mid-period never truncates the period.
- PWM compare, one-cycle registered latency:
  - In RUN, PWM_OUT[i] <= (cnt < DUTY_active[i]), using the cnt value before the edge's update.
  - duty=0 gives constant low; duty > PERIOD gives constant high.
  - Comparison is unsigned, WIDTH bits.
- Config handshake:
  - CFG_READY=0 only in the cycle the boundary copy occurs (wrap-tick in RUN, or the IDLE->RUN transition). A write presented in that cycle is held by the master and accepted the next cycle, so it lands in the next period.
  - A write updates only the shadow copy, written at the accepting edge.
  - Writes are accepted in every state.
  - For an invalid address the write is dropped and CFG_ERR pulses for one cycle.
- Simultaneous events:
  - EN falling in the same cycle as a wrap: the DRAIN path is taken; the copy still happens.
  - Period lowered below the current cnt: takes effect only after the next wrap, so no early wrap can occur.
- Mid-operation reset: async, immediately returns to the reset values above; in-flight config writes are lost.

Test Plan:
- Reset/defaults: release RST, EN=1, no config -> period 15; PWM_OUT=0 (duty 0); PERIOD_TICK every 16 cycles.
- Basic duty: write ch0 duty=4, ch1 duty=12, then EN=1 -> per 16-cycle period, ch0 high 4 cycles and ch1 high 12 cycles; outputs lag cnt by 1 cycle.
- Shadow timing:
  - While running with ch0 duty=4, write duty=8 mid-period -> the current period still shows 4 high cycles and the next period shows 8.
  - A write issued on the wrap cycle sees CFG_READY=0 and lands one period later.
- Prescale: PRESC=2, PERIOD=3, duty=2 -> period of 12 clocks, PWM_OUT high 6 clocks, PERIOD_TICK every 12 clocks.
- Stop/drain and edge duties:
  - EN=0 at cnt=5 with PERIOD=15 -> counting continues to the wrap, one DRAIN cycle, then IDLE; BUSY falls, PWM_OUT=0.
  - duty=0 gives constant low; duty=15 with PERIOD=14 gives constant high.
- Error and async reset:
  - Write to addr 7 with NCH=4 -> CFG_ERR pulses for 1 cycle; no register changes.
  - RST low mid-period -> outputs 0 immediately, and defaults restored.

Source files
------------

// File: rtl/pwm_sequencer_if.sv
// Config write port for pwm_sequencer: valid/ready write channel plus an
// error pulse reported back to the host.
interface pwm_sequencer_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8
) ();
  logic          valid;
  logic          ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          err;

  modport master (output valid, addr, data, input ready, err);
  modport slave  (input valid, addr, data, output ready, err);
endinterface

// File: rtl/pwm_sequencer.sv
// Multi-channel PWM with one shared, prescaled period counter. Config writes
// land in shadow registers and are promoted to active only at period boundaries.
module pwm_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCH   = 4,
  parameter int unsigned PW    = 8,
  parameter int unsigned AW    = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  pwm_sequencer_if.slave    cfg,
  output logic [NCH-1:0]    pwm_o,
  output logic              period_tick_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                     state_q, state_d;
  logic [WIDTH-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]              psc_q, psc_d;
  logic [NCH-1:0][WIDTH-1:0]  duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
  logic [WIDTH-1:0]           per_sh_q, per_sh_d, per_act_q, per_act_d;
  logic [PW-1:0]              presc_sh_q, presc_sh_d, presc_act_q, presc_act_d;
  logic [NCH-1:0]             pwm_q, pwm_d;
  logic                       tick_q, tick_d;
  logic                       err_q, err_d;

  logic        tick;
  logic        wrap;
  logic        copy;
  logic        accept;
  logic [31:0] addr_ext;

  assign tick     = (psc_q == presc_act_q);
  assign wrap     = (state_q == StRun) && tick && (cnt_q == per_act_q);
  // Ready drops only while shadows are being promoted, so a write can never
  // race with the copy and always lands cleanly in one period or the next.
  assign copy     = wrap || ((state_q == StIdle) && en_i);
  assign accept   = cfg.valid && !copy;
  assign addr_ext = 32'(cfg.addr);

  assign cfg.ready     = !copy;
  assign cfg.err       = err_q;
  assign pwm_o         = pwm_q;
  assign period_tick_o = tick_q;
  assign busy_o        = (state_q != StIdle);

  always_comb begin
    duty_sh_d  = duty_sh_q;
    per_sh_d   = per_sh_q;
    presc_sh_d = presc_sh_q;
    err_d      = 1'b0;
    if (accept) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (addr_ext == i) duty_sh_d[i] = cfg.data[WIDTH-1:0];
      end
      if (addr_ext == NCH) begin
        per_sh_d = cfg.data[WIDTH-1:0];
      end else if (addr_ext == NCH + 1) begin
        presc_sh_d = cfg.data[PW-1:0];
      end else if (addr_ext >= NCH + 2) begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psc_d       = psc_q;
    pwm_d       = '0;
    tick_d      = 1'b0;
    duty_act_d  = duty_act_q;
    per_act_d   = per_act_q;
    presc_act_d = presc_act_q;

    if (copy) begin
      duty_act_d  = duty_sh_q;
      per_act_d   = per_sh_q;
      presc_act_d = presc_sh_q;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        psc_d = '0;
        if (en_i) state_d = StRun;
      end
      StRun: begin
        psc_d = tick ? '0 : psc_q + 1'b1;
        for (int unsigned i = 0; i < NCH; i++) begin
          pwm_d[i] = (cnt_q < duty_act_q[i]);
        end
        if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (!en_i) state_d = StDrain;
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        cnt_d   = '0;
        psc_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      psc_q       <= '0;
      duty_sh_q   <= '0;
      duty_act_q  <= '0;
      per_sh_q    <= '1;
      per_act_q   <= '1;
      presc_sh_q  <= '0;
      presc_act_q <= '0;
      pwm_q       <= '0;
      tick_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psc_q       <= psc_d;
      duty_sh_q   <= duty_sh_d;
      duty_act_q  <= duty_act_d;
      per_sh_q    <= per_sh_d;
      per_act_q   <= per_act_d;
      presc_sh_q  <= presc_sh_d;
      presc_act_q <= presc_act_d;
      pwm_q       <= pwm_d;
      tick_q      <= tick_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Scoreboard bench for pwm_sequencer: a period-level model predicts each
// period's length and per-channel high time; a monitor checks them at each tick.
module tb_pwm_sequencer;
  localparam int NCH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic [NCH-1:0] pwm;
  logic tick;
  logic busy;

  pwm_sequencer_if #(.AW(3), .DW(8)) cfg_if ();

  pwm_sequencer #(.WIDTH(4), .NCH(NCH), .PW(8), .AW(3)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .cfg           (cfg_if.slave),
    .pwm_o         (pwm),
    .period_tick_o (tick),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (period granularity) ----------------
  typedef struct {
    int len;
    int hi [NCH];
  } exp_t;

  exp_t expq[$];
  int   m_phase;   // 0 idle, 1 running, 2 draining
  int   m_rem;     // clocks left in the current period, including this one
  bit   m_err, m_tick;
  int   sh_duty [NCH];
  int   sh_per, sh_psc, act_per, act_psc;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit m_ready();
    return !((m_phase == 0 && en) || (m_phase == 1 && m_rem == 1));
  endfunction

  task automatic model_reset();
    m_phase = 0; m_rem = 0; m_err = 0; m_tick = 0;
    foreach (sh_duty[i]) sh_duty[i] = 0;
    sh_per = 15; sh_psc = 0; act_per = 15; act_psc = 0;
    expq.delete();
  endtask

  // Promote shadows and predict the whole upcoming period at once.
  task automatic start_period();
    exp_t e;
    act_per = sh_per;
    act_psc = sh_psc;
    e.len   = (act_per + 1) * (act_psc + 1);
    foreach (e.hi[i]) e.hi[i] = imin(sh_duty[i], act_per + 1) * (act_psc + 1);
    m_rem = e.len;
    expq.push_back(e);
  endtask

  task automatic model_step();
    bit acc;
    int a, d;
    acc    = cfg_if.valid && m_ready();
    a      = int'(cfg_if.addr);
    d      = int'(cfg_if.data);
    m_err  = acc && (a >= NCH + 2);
    m_tick = 0;
    case (m_phase)
      0: if (en) begin start_period(); m_phase = 1; end
      1: begin
        if (m_rem == 1) begin
          m_tick = 1;
          if (en) start_period();
          else begin act_per = sh_per; act_psc = sh_psc; m_phase = 2; end
        end else begin
          m_rem--;
        end
      end
      default: m_phase = 0;
    endcase
    if (acc) begin
      if (a < NCH) sh_duty[a] = d & 15;
      else if (a == NCH) sh_per = d & 15;
      else if (a == NCH + 1) sh_psc = d & 255;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int   len;
    int   hi [NCH];
    bit   bprev;
    exp_t e;
    len = 0; bprev = 0;
    foreach (hi[i]) hi[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        len = 0; bprev = 0;
        foreach (hi[i]) hi[i] = 0;
      end else begin
        check("busy", busy, int'(m_phase != 0));
        check("cfg_ready", cfg_if.ready, m_ready());
        check("cfg_err", cfg_if.err, m_err);
        check("period_tick", tick, m_tick);
        if (m_phase == 0) check("pwm_idle", pwm, 0);
        if (!bprev) begin
          len = 0;
          foreach (hi[i]) hi[i] = 0;
        end else begin
          len++;
          foreach (hi[i]) hi[i] += pwm[i];
        end
        if (tick) begin
          if (expq.size() == 0) begin
            check("tick_unexpected", 1, 0);
          end else begin
            e = expq.pop_front();
            check("period_len", len, e.len);
            foreach (hi[i]) check($sformatf("high_ch%0d", i), hi[i], e.hi[i]);
          end
          len = 0;
          foreach (hi[i]) hi[i] = 0;
        end
        bprev = busy;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input int a, input int d);
    bit acc;
    bit done;
    done          = 0;
    cfg_if.valid  = 1'b1;
    cfg_if.addr   = 3'(a);
    cfg_if.data   = 8'(d);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      acc = cfg_if.ready;
      @(posedge clk);
      #1;
      done = acc;
    end
    if (!done) check("write_timeout", 0, 1);
    cfg_if.valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      done = !busy;
    end
    if (!done) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int op, a, d;
    cfg_if.valid = 1'b0;
    cfg_if.addr  = '0;
    cfg_if.data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", pwm, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", tick, 0);
    check("rst_err", cfg_if.err, 0);
    check("rst_ready", cfg_if.ready, 1);
    rst_n = 1'b1;
    run(1);

    en = 1'b1;                               // defaults: period 15, duty 0
    run(40);
    en = 1'b0;
    wait_idle();
    write(0, 4); write(1, 12);
    en = 1'b1;
    run(40);
    run(5);
    write(0, 8);                             // mid-period shadow update
    run(40);
    write(NCH, 3); write(NCH + 1, 2); write(0, 2);
    run(40);
    write(NCH, 14); write(0, 0); write(1, 15);
    run(40);
    write(7, 9);                             // invalid address
    run(20);
    write(NCH, 15); write(NCH + 1, 0);
    run(20);
    en = 1'b0;                               // stop mid-period
    wait_idle();
    run(3);

    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 9);
      if (op < 5) begin
        a = $urandom_range(0, 7);
        d = $urandom_range(0, 255);
        if (a == NCH + 1) d = d & 3;
        write(a, d);
      end else if (op < 7) begin
        en = 1'($urandom_range(0, 1));
      end else begin
        run($urandom_range(1, 20));
      end
    end

    en = 1'b1;
    run(7);
    #2;
    rst_n = 1'b0;                            // async reset mid-period
    #1;
    check("arst_pwm", pwm, 0);
    check("arst_busy", busy, 0);
    check("arst_tick", tick, 0);
    check("arst_err", cfg_if.err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(40);
    en = 1'b0;
    wait_idle();
    run(3);
    check("exp_queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
